tile_spectrum_writer: RTL and testbench
=======================================

TILE_SPECTRUM_WRITER -- requirements
Module: tile_spectrum_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, cacheline address width.
REQ-002 SHALL have parameter DEPTH, default 2, tile buffer depth in tiles; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
REQ-005 in_next  input  1  pulse; a valid tile is on in during the following cycle.
REQ-006 in  input  complex_t [0:3][0:3]  4x4 complex frequency tile; 32-bit r, 32-bit i per element.
REQ-007 cfg_load  input  1  pulse; loads cfg_base_addr into the address counter.
REQ-008 cfg_base_addr  input  ADDR_W  starting cacheline address.
REQ-009 wr_valid  output  1  a cacheline beat is offered.
REQ-010 wr_ready  input  1  memory write path accepts the beat.
REQ-011 wr_data  output  512  cacheline payload.
REQ-012 wr_addr  output  ADDR_W  cacheline address of the current beat.
REQ-013 wr_last  output  1  current beat is the second (final) beat of a tile.
REQ-014 overflow  output  1  sticky; at least one tile has been dropped.
REQ-015 tiles_written  output  16  count of fully written tiles.

Function
REQ-016 SHALL register in_next; the tile is captured from in on the cycle after in_next is sampled high (capture cycle).
REQ-017 SHALL accept back-to-back in_next pulses on consecutive cycles; each pulse captures exactly one tile.
REQ-018 Capture SHALL push the tile into a DEPTH-entry FIFO of 1024-bit entries.
REQ-019 Push when full SHALL be accepted only if a pop occurs in the same cycle; the count remains full.
REQ-020 Push when full without a same-cycle pop SHALL drop the tile, set overflow, and leave the FIFO unchanged.
REQ-021 Entry packing SHALL be as follows: beat 0 holds rows 0-1 and beat 1 holds rows 2-3.
REQ-022 Within a beat, element (row, col) SHALL use n = 4*(row mod 2) + col, with wr_data[64n+31:64n] = r and wr_data[64n+63:64n+32] = i.
REQ-023 SHALL keep a 1-bit phase register selecting beat 0 or beat 1 of the FIFO head.
REQ-024 wr_valid SHALL be 1 whenever the FIFO is non-empty; wr_data SHALL be the head beat selected by phase; wr_last SHALL equal phase.
REQ-025 A handshake occurs when wr_valid and wr_ready are both 1.
REQ-026 On a handshake in phase 0, phase SHALL go to 1.
REQ-027 On a handshake in phase 1, phase SHALL go to 0, the head SHALL be popped, and tiles_written SHALL increment.
REQ-028 tiles_written SHALL wrap 0xFFFF to 0.
REQ-029 While wr_valid is 1 and wr_ready is 0, wr_data, wr_addr and wr_last SHALL hold stable.
REQ-030 wr_addr SHALL increment by 1 per handshake, wrapping at 2^ADDR_W - 1 to 0.
REQ-031 cfg_load SHALL set the address counter to cfg_base_addr on the next edge and SHALL take priority over a same-cycle handshake increment.
REQ-032 cfg_load SHALL NOT affect the FIFO, phase or counters.
REQ-033 Latency: with the FIFO empty, in_next at cycle T SHALL give capture at T+1 and wr_valid high at T+2.
REQ-034 Sustained throughput SHALL be one beat per cycle with wr_ready held high, i.e. one tile per 2 cycles.
REQ-035 Capture into an empty FIFO and pop of the last entry SHALL NOT occur in the same cycle; empty means no pop is possible.

Reset
REQ-036 When reset is asserted, the outputs SHALL be: wr_valid 0, wr_last 0, wr_addr 0, wr_data 0, overflow 0, tiles_written 0.
REQ-037 When reset is asserted, the FIFO SHALL be empty, phase SHALL be 0, and any pending in_next SHALL be discarded.
REQ-038 Reset asserted mid-tile (after beat 0 is accepted) SHALL abandon the tile; after release, no beat is emitted until a new capture.

Verification
REQ-039 Single tile: with base 0x100, in[r][c] = {i: 16r+c+0x80, r: 16r+c} and wr_ready = 1 -> 2 beats at addresses 0x100 and 0x101, wr_last = 0 then 1, packing per REQ-021/REQ-022, tiles_written = 1.
REQ-040 Backpressure: hold wr_ready = 0 for 5 cycles after wr_valid rises -> wr_data and wr_addr stable for those cycles, then 2 beats complete.
REQ-041 Overflow: DEPTH = 2 with wr_ready = 0, issue 3 in_next pulses -> overflow = 1, then 4 beats delivered (first two tiles only), tiles_written = 2.
REQ-042 Full with simultaneous pop: FIFO full, beat 1 handshake in the same cycle as a capture -> tile accepted, overflow stays 0.
REQ-043 Address wrap: ADDR_W = 8, base 0xFF -> beats at 0xFF then 0x00; cfg_load during a stall -> next beat uses the new base.
REQ-044 Reset mid-tile: assert reset after beat 0 is accepted -> all outputs 0; after release, no wr_valid until a new in_next.

Source files
------------

// File: rtl/tile_spectrum_writer_if.sv
// Tile element types and the cacheline write bus of tile_spectrum_writer.
// The writer drives the master side of the bus and the memory path drives the slave side.
package tile_spectrum_pkg;
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] r;
  } complex_t;
  typedef complex_t [0:3][0:3] tile_t;
endpackage

interface tile_spectrum_writer_if #(
  parameter int ADDR_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [511:0]      wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;

  modport master (output wr_valid, output wr_data, output wr_addr, output wr_last,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, input  wr_addr, input  wr_last,
                  output wr_ready);
endinterface

// File: rtl/tile_spectrum_writer.sv
// Buffers 4x4 complex spectrum tiles in a small FIFO and streams each one
// as two 512-bit cacheline beats at consecutive addresses.
module tile_spectrum_writer
  import tile_spectrum_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_next,
  input  tile_t                 in,
  input  logic                  cfg_load,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  tile_spectrum_writer_if.master wr,
  output logic                  overflow,
  output logic [15:0]           tiles_written
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } phase_t;

  phase_t            phase_q, phase_d;
  logic              cap_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1023:0]     mem [DEPTH];
  logic [1023:0]     cap_entry;
  logic [1023:0]     head;
  logic              empty, full, hs, pop, push, drop;

  // Element (row, col) lands at 64-bit slot 4*row+col, so rows 0-1 fill the
  // low half (beat 0) and rows 2-3 the high half (beat 1).
  always_comb begin
    cap_entry = '0;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        cap_entry[64*(4*row+col) +: 64] = {in[row][col].i, in[row][col].r};
      end
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign hs    = wr.wr_valid && wr.wr_ready;
  assign pop   = hs && (phase_q == BEAT1);
  // A full FIFO still takes a tile when its head leaves in the same cycle.
  assign push  = cap_q && (!full || pop);
  assign drop  = cap_q && full && !pop;
  assign head  = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= BEAT0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    wr.wr_valid = !empty;
    wr.wr_last  = (phase_q == BEAT1);
    wr.wr_addr  = addr_q;
    wr.wr_data  = '0;
    if (!empty) begin
      wr.wr_data = (phase_q == BEAT1) ? head[1023:512] : head[511:0];
    end
    if (hs) begin
      phase_d = (phase_q == BEAT0) ? BEAT1 : BEAT0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= cap_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      overflow      <= 1'b0;
      tiles_written <= '0;
    end else begin
      cap_q   <= in_next;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
        tiles_written <= tiles_written + 16'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (cfg_load) begin
        addr_q <= cfg_base_addr;
      end else if (hs) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tile_spectrum_writer.sv
// Self-checking bench for tile_spectrum_writer: directed scenarios plus random
// traffic against a beat-queue reference model; a second 8-bit-address instance shares stimulus.
module tb_tile_spectrum_writer;
  import tile_spectrum_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_next;
  logic        cfg_load;
  logic        ready;
  logic [31:0] base;
  tile_t       tile_in;
  logic        ovf32, ovf8;
  logic [15:0] tw32, tw8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tile_spectrum_writer_if #(.ADDR_W(32)) bus32 ();
  tile_spectrum_writer_if #(.ADDR_W(8))  bus8 ();
  assign bus32.wr_ready = ready;
  assign bus8.wr_ready  = ready;

  tile_spectrum_writer #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_next(in_next), .in(tile_in),
    .cfg_load(cfg_load), .cfg_base_addr(base), .wr(bus32.master),
    .overflow(ovf32), .tiles_written(tw32)
  );

  tile_spectrum_writer #(.ADDR_W(8), .DEPTH(DEPTH)) dut8 (
    .clk(clk), .reset(reset), .in_next(in_next), .in(tile_in),
    .cfg_load(cfg_load), .cfg_base_addr(base[7:0]), .wr(bus8.master),
    .overflow(ovf8), .tiles_written(tw8)
  );

  // Reference model: a queue of pending beats, two per accepted tile.
  typedef struct {
    logic [511:0] data;
    logic         last;
  } beat_t;

  beat_t       bq[$];
  logic [31:0] m_addr;
  logic [15:0] m_written;
  logic        m_ovf;
  logic        m_pend;

  function automatic logic [511:0] pack_beat(input tile_t t, input int b);
    logic [511:0] d = '0;
    for (int row = 2*b; row < 2*b + 2; row++) begin
      for (int col = 0; col < 4; col++) begin
        int n = 4*(row % 2) + col;
        d[64*n +: 32]      = t[row][col].r;
        d[64*n + 32 +: 32] = t[row][col].i;
      end
    end
    return d;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        t[row][col].r = $urandom;
        t[row][col].i = $urandom;
      end
    end
    return t;
  endfunction

  function automatic logic exp_valid();
    return bq.size() != 0;
  endfunction

  function automatic logic [511:0] exp_data();
    return (bq.size() != 0) ? bq[0].data : '0;
  endfunction

  function automatic logic exp_last();
    return (bq.size() != 0) ? bq[0].last : 1'b0;
  endfunction

  task automatic model_reset();
    bq.delete();
    m_addr    = '0;
    m_written = '0;
    m_ovf     = 1'b0;
    m_pend    = 1'b0;
  endtask

  task automatic model_step();
    bit    hs;
    bit    pop_tile;
    int    tiles;
    beat_t b;
    hs       = (bq.size() != 0) && ready;
    pop_tile = 1'b0;
    if (hs) pop_tile = bq[0].last;
    tiles = (bq.size() + 1) / 2;
    if (hs) begin
      void'(bq.pop_front());
      if (pop_tile) m_written++;
    end
    if (m_pend) begin
      if (tiles < DEPTH || pop_tile) begin
        b.data = pack_beat(tile_in, 0); b.last = 1'b0; bq.push_back(b);
        b.data = pack_beat(tile_in, 1); b.last = 1'b1; bq.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (cfg_load) m_addr = base;
    else if (hs)  m_addr = m_addr + 32'd1;
    m_pend = in_next;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_next = 1'b0; cfg_load = 1'b0; ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_next = 1'b0; cfg_load = 1'b0; ready = 1'b0;
    base = '0; tile_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus32.wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus32.wr_valid); end
    n_tests++; if (bus32.wr_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", bus32.wr_last); end
    n_tests++; if (bus32.wr_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus32.wr_addr); end
    n_tests++; if (bus32.wr_data !== 512'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus32.wr_data[63:0]); end
    n_tests++; if (ovf32 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", ovf32); end
    n_tests++; if (tw32 !== 16'd0) begin n_fail++; $display("FAIL reset_tiles: got %0d want 0", tw32); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_tile();
    logic [511:0] b0, b1;
    base = 32'h100; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        tile_in[row][col].r = 32'(16*row + col);
        tile_in[row][col].i = 32'(16*row + col + 'h80);
      end
    end
    b0 = pack_beat(tile_in, 0);
    b1 = pack_beat(tile_in, 1);
    ready = 1'b1; in_next = 1'b1; tick(); in_next = 1'b0;
    n_tests++; if (bus32.wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_t1: valid %0b want 0", bus32.wr_valid); end
    tick();
    n_tests++; if (bus32.wr_valid !== 1'b1 || bus32.wr_addr !== 32'h100 || bus32.wr_last !== 1'b0 || bus32.wr_data !== b0) begin
      n_fail++; $display("FAIL single_beat0: valid %0b addr %h last %0b data %h want 1 100 0 %h",
                         bus32.wr_valid, bus32.wr_addr, bus32.wr_last, bus32.wr_data[127:0], b0[127:0]);
    end
    tick();
    n_tests++; if (bus32.wr_valid !== 1'b1 || bus32.wr_addr !== 32'h101 || bus32.wr_last !== 1'b1 || bus32.wr_data !== b1) begin
      n_fail++; $display("FAIL single_beat1: valid %0b addr %h last %0b data %h want 1 101 1 %h",
                         bus32.wr_valid, bus32.wr_addr, bus32.wr_last, bus32.wr_data[127:0], b1[127:0]);
    end
    tick();
    n_tests++; if (bus32.wr_valid !== 1'b0 || tw32 !== 16'd1) begin
      n_fail++; $display("FAIL single_done: valid %0b tiles %0d want 0 1", bus32.wr_valid, tw32);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] d0;
    logic [31:0]  a0;
    tile_in = rand_tile();
    ready = 1'b0; in_next = 1'b1; tick(); in_next = 1'b0; tick();
    d0 = bus32.wr_data; a0 = bus32.wr_addr;
    n_tests++; if (bus32.wr_valid !== 1'b1 || d0 !== pack_beat(tile_in, 0) || a0 !== m_addr) begin
      n_fail++; $display("FAIL bp_first: valid %0b addr %h want 1 %h", bus32.wr_valid, a0, m_addr);
    end
    for (int k = 0; k < 5; k++) begin
      tile_in = rand_tile();
      tick();
      n_tests++; if (bus32.wr_data !== d0 || bus32.wr_addr !== a0 || bus32.wr_last !== 1'b0 || bus32.wr_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_stable[%0d]: addr %h last %0b want %h 0", k, bus32.wr_addr, bus32.wr_last, a0);
      end
    end
    ready = 1'b1; tick();
    n_tests++; if (bus32.wr_last !== 1'b1 || bus32.wr_data !== exp_data() || bus32.wr_addr !== a0 + 32'd1) begin
      n_fail++; $display("FAIL bp_beat1: last %0b addr %h want 1 %h", bus32.wr_last, bus32.wr_addr, a0 + 32'd1);
    end
    tick();
    n_tests++; if (bus32.wr_valid !== 1'b0 || tw32 !== m_written) begin
      n_fail++; $display("FAIL bp_done: valid %0b tiles %0d want 0 %0d", bus32.wr_valid, tw32, m_written);
    end
  endtask

  task automatic test_overflow();
    int beats = 0;
    do_reset();
    ready = 1'b0; in_next = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tile_in = rand_tile(); tick();
    end
    in_next = 1'b0; tile_in = rand_tile(); tick(); tick();
    n_tests++; if (ovf32 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", ovf32); end
    ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus32.wr_valid) begin
        beats++;
        n_tests++; if (bus32.wr_data !== exp_data() || bus32.wr_last !== exp_last()) begin
          n_fail++; $display("FAIL ovf_beat%0d: last %0b want %0b", beats, bus32.wr_last, exp_last());
        end
      end
      tick();
    end
    n_tests++; if (beats != 4 || tw32 !== 16'd2 || ovf32 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain: beats %0d tiles %0d ovf %0b want 4 2 1", beats, tw32, ovf32);
    end
  endtask

  task automatic test_full_pop();
    int beats = 0;
    do_reset();
    ready = 1'b0; in_next = 1'b1;
    tile_in = rand_tile(); tick();
    tile_in = rand_tile(); tick();
    in_next = 1'b0; tile_in = rand_tile(); tick(); tick();
    ready = 1'b1; in_next = 1'b1; tick();
    in_next = 1'b0; tile_in = rand_tile(); tick();
    n_tests++; if (ovf32 !== 1'b0 || m_ovf !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_ovf: got %0b want 0", ovf32);
    end
    for (int k = 0; k < 10; k++) begin
      if (bus32.wr_valid) begin
        beats++;
        n_tests++; if (bus32.wr_data !== exp_data() || bus32.wr_last !== exp_last()) begin
          n_fail++; $display("FAIL fullpop_beat%0d: last %0b want %0b", beats, bus32.wr_last, exp_last());
        end
      end
      tick();
    end
    n_tests++; if (beats != 4 || tw32 !== 16'd3) begin
      n_fail++; $display("FAIL fullpop_drain: beats %0d tiles %0d want 4 3", beats, tw32);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, cnt = 0;
    logic [15:0] tw0;
    tw0 = tw32;
    ready = 1'b1; in_next = 1'b1;
    tile_in = rand_tile(); tick();
    tile_in = rand_tile(); tick();
    in_next = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tile_in = rand_tile();
      n_tests++; if (bus32.wr_valid !== exp_valid() || bus32.wr_data !== exp_data() || bus32.wr_last !== exp_last()) begin
        n_fail++; $display("FAIL b2b_cyc%0d: valid %0b last %0b want %0b %0b", k, bus32.wr_valid, bus32.wr_last, exp_valid(), exp_last());
      end
      if (bus32.wr_valid) begin
        cnt++; last = k;
        if (first < 0) first = k;
      end
      tick();
    end
    n_tests++; if (cnt != 4 || last - first != 3 || tw32 !== tw0 + 16'd2 || ovf32 !== m_ovf) begin
      n_fail++; $display("FAIL b2b_rate: beats %0d span %0d tiles %0d want 4 3 %0d", cnt, last - first, tw32, tw0 + 16'd2);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    base = 32'hFF; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    ready = 1'b1; in_next = 1'b1; tile_in = rand_tile(); tick(); in_next = 1'b0; tick();
    n_tests++; if (bus8.wr_addr !== 8'hFF || bus8.wr_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_first: addr %h valid %0b want ff 1", bus8.wr_addr, bus8.wr_valid);
    end
    tick();
    n_tests++; if (bus8.wr_addr !== 8'h00 || bus8.wr_last !== 1'b1 || bus32.wr_addr !== 32'h100) begin
      n_fail++; $display("FAIL wrap_second: addr8 %h addr32 %h want 00 100", bus8.wr_addr, bus32.wr_addr);
    end
    tick();
    ready = 1'b0; in_next = 1'b1; tile_in = rand_tile(); tick(); in_next = 1'b0; tick();
    base = 32'h40; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    n_tests++; if (bus8.wr_addr !== 8'h40 || bus32.wr_addr !== 32'h40 || bus8.wr_last !== 1'b0) begin
      n_fail++; $display("FAIL wrap_reload: addr8 %h addr32 %h want 40 40", bus8.wr_addr, bus32.wr_addr);
    end
    ready = 1'b1; tick();
    n_tests++; if (bus8.wr_addr !== 8'h41 || bus8.wr_last !== 1'b1) begin
      n_fail++; $display("FAIL wrap_after_reload: addr %h last %0b want 41 1", bus8.wr_addr, bus8.wr_last);
    end
    tick();
    in_next = 1'b1; tile_in = rand_tile(); tick(); in_next = 1'b0; tick();
    base = 32'h10; cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    n_tests++; if (bus32.wr_addr !== 32'h10 || bus32.wr_last !== 1'b1) begin
      n_fail++; $display("FAIL load_priority: addr %h last %0b want 10 1", bus32.wr_addr, bus32.wr_last);
    end
    tick();
  endtask

  task automatic test_reset_mid_tile();
    do_reset();
    ready = 1'b1; in_next = 1'b1; tile_in = rand_tile(); tick(); in_next = 1'b0;
    tick(); tick();
    ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_tests++; if (bus32.wr_valid !== 1'b0 || bus32.wr_last !== 1'b0 || bus32.wr_addr !== 32'd0 ||
                   bus32.wr_data !== 512'd0 || ovf32 !== 1'b0 || tw32 !== 16'd0) begin
      n_fail++; $display("FAIL midreset_outputs: valid %0b last %0b addr %h ovf %0b tiles %0d want all 0",
                         bus32.wr_valid, bus32.wr_last, bus32.wr_addr, ovf32, tw32);
    end
    @(posedge clk);
    #1;
    reset = 1'b1; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++; if (bus32.wr_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_idle[%0d]: valid %0b want 0", k, bus32.wr_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      in_next  = ($urandom_range(2) == 0);
      ready    = ($urandom_range(3) != 0);
      cfg_load = ($urandom_range(19) == 0);
      base     = $urandom;
      tile_in  = rand_tile();
      n_tests++;
      if (bus32.wr_valid !== exp_valid() || bus32.wr_data !== exp_data() || bus32.wr_last !== exp_last() ||
          bus32.wr_addr !== m_addr || bus8.wr_addr !== m_addr[7:0] || ovf32 !== m_ovf || tw32 !== m_written ||
          bus8.wr_valid !== exp_valid() || ovf8 !== m_ovf || tw8 !== m_written) begin
        n_fail++;
        $display("FAIL random_cyc%0d: valid %0b/%0b last %0b/%0b addr %h/%h addr8 %h ovf %0b/%0b tiles %0d/%0d data %h/%h",
                 k, bus32.wr_valid, exp_valid(), bus32.wr_last, exp_last(), bus32.wr_addr, m_addr, bus8.wr_addr,
                 ovf32, m_ovf, tw32, m_written, bus32.wr_data[63:0], exp_data() & 512'hFFFF_FFFF_FFFF_FFFF);
      end
      tick();
    end
    in_next = 1'b0; cfg_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_tile();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
